// File: rtl/udcnt_seq.sv
// udcnt_seq: up/down triangle sweep counter between captured limits lo_r and hi_r.
// One triangle then a done pulse (mode 0), or repeated triangles until stop (mode 1).
module udcnt_seq #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         stop,
   input  logic         mode,
   input  logic [N-1:0] lo,
   input  logic [N-1:0] hi,
   output logic [N-1:0] q,
   output logic         ud,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [7:0]   laps
);

   typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;

   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   state_t       state_reg, state_next;
   logic [N-1:0] q_reg, q_next;
   logic [N-1:0] lo_r, lo_next;
   logic [N-1:0] hi_r, hi_next;
   logic         mode_r, mode_next;
   logic [7:0]   laps_reg, laps_next;
   logic         err_reg, err_next;

   // state and datapath registers; reset clears everything at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         q_reg     <= '0;
         lo_r      <= '0;
         hi_r      <= '0;
         mode_r    <= 1'b0;
         laps_reg  <= 8'd0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         q_reg     <= q_next;
         lo_r      <= lo_next;
         hi_r      <= hi_next;
         mode_r    <= mode_next;
         laps_reg  <= laps_next;
         err_reg   <= err_next;
      end
   end

   // next-state and datapath update; stop outranks the limit turns
   always_comb begin
      state_next = state_reg;
      q_next     = q_reg;
      lo_next    = lo_r;
      hi_next    = hi_r;
      mode_next  = mode_r;
      laps_next  = laps_reg;
      err_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               if (lo < hi) begin
                  lo_next    = lo;
                  hi_next    = hi;
                  mode_next  = mode;
                  q_next     = lo;
                  laps_next  = 8'd0;
                  state_next = UP;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         UP: begin
            if (stop) begin
               state_next = IDLE;
            end else if (q_reg == hi_r) begin
               // turn at the peak without a hold cycle
               q_next     = q_reg - ONE;
               state_next = DOWN;
            end else begin
               q_next = q_reg + ONE;
            end
         end
         DOWN: begin
            if (stop) begin
               state_next = IDLE;
            end else if (q_reg == lo_r) begin
               laps_next = laps_reg + 8'd1;
               if (mode_r) begin
                  q_next     = lo_r + ONE;
                  state_next = UP;
               end else begin
                  state_next = DONE;
               end
            end else begin
               q_next = q_reg - ONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign q    = q_reg;
   assign laps = laps_reg;
   assign err  = err_reg;
   assign ud   = (state_reg == DOWN);
   assign busy = (state_reg == UP) || (state_reg == DOWN);
   assign done = (state_reg == DONE);

endmodule

// File: tb/tb_udcnt_seq.sv
// Scoreboard bench for udcnt_seq: the driver pushes the expected post-edge outputs,
// a monitor pops and compares one record after every rising edge.
module tb_udcnt_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       mode = 1'b0;
   logic [3:0] lo = 4'd0;
   logic [3:0] hi = 4'd0;
   logic [3:0] q;
   logic       ud, busy, done, err;
   logic [7:0] laps;

   typedef struct packed {
      logic [3:0] q;
      logic       ud;
      logic       busy;
      logic       done;
      logic       err;
      logic [7:0] laps;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   txn = 0;

   // hand-computed sequences
   int tri_q[7]  = '{2, 3, 4, 5, 4, 3, 2};
   bit tri_ud[7] = '{0, 0, 0, 0, 1, 1, 1};
   int bq[20]    = '{0,1,2,3,2,1,0, 1,2,3,2,1,0, 1,2,3,2,1,0, 1};
   bit bud[20]   = '{0,0,0,0,1,1,1, 0,0,0,1,1,1, 0,0,0,1,1,1, 0};
   int bl[20]    = '{0,0,0,0,0,0,0, 1,1,1,1,1,1, 2,2,2,2,2,2, 3};

   udcnt_seq #(.N(4)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
      .lo(lo), .hi(hi), .q(q), .ud(ud), .busy(busy), .done(done),
      .err(err), .laps(laps)
   );

   always #5 clk = ~clk;

   // drive inputs now and queue the outputs expected after the next rising edge
   task automatic drive(input logic st, input logic sp, input logic md,
                        input logic [3:0] l, input logic [3:0] h,
                        input int eq, input logic eud, input logic ebusy,
                        input logic edone, input logic eerr, input int elaps);
      obs_t e;
      start = st; stop = sp; mode = md; lo = l; hi = h;
      e.q = 4'(eq); e.ud = eud; e.busy = ebusy; e.done = edone;
      e.err = eerr; e.laps = 8'(elaps);
      exp_q.push_back(e);
   endtask

   task automatic step(input logic st, input logic sp, input logic md,
                       input logic [3:0] l, input logic [3:0] h,
                       input int eq, input logic eud, input logic ebusy,
                       input logic edone, input logic eerr, input int elaps);
      @(negedge clk);
      drive(st, sp, md, l, h, eq, eud, ebusy, edone, eerr, elaps);
   endtask

   // lo=2 hi=5 mode=0 triangle; perturb keeps start high and changes lo/hi/mode mid-sweep
   task automatic tri_run(input bit wait_first, input bit perturb);
      for (int i = 0; i < 7; i++) begin
         if (i > 0 || wait_first) @(negedge clk);
         if (i == 0)
            drive(1, 0, 0, 2, 5, tri_q[i], tri_ud[i], 1, 0, 0, 0);
         else if (perturb)
            drive(1, 0, 1, 0, 15, tri_q[i], tri_ud[i], 1, 0, 0, 0);
         else
            drive(0, 0, 0, 2, 5, tri_q[i], tri_ud[i], 1, 0, 0, 0);
      end
      step(perturb, 0, perturb, 2, 5, 2, 0, 0, 1, 0, 1);
      step(perturb, 0, perturb, 2, 5, 2, 0, 0, 0, 0, 1);
      step(0, 0, 0, 2, 5, 2, 0, 0, 0, 0, 1);
   endtask

   // immediate check that every output sits at its reset value
   task automatic chk_reset(input string name);
      checks++;
      if ({q, ud, busy, done, err, laps} !== '0) begin
         failures++;
         $display("FAIL %s: got q=%0d ud=%b busy=%b done=%b err=%b laps=%0d, want all zero",
                  name, q, ud, busy, done, err, laps);
      end else begin
         $display("%s ok: outputs at reset values", name);
      end
   endtask

   // monitor: one comparison per rising edge while expectations are pending
   initial begin
      obs_t a, e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.q = q; a.ud = ud; a.busy = busy; a.done = done; a.err = err; a.laps = laps;
            txn++;
            checks++;
            if (a !== e) begin
               failures++;
               $display("FAIL txn%0d: got q=%0d ud=%b busy=%b done=%b err=%b laps=%0d, want q=%0d ud=%b busy=%b done=%b err=%b laps=%0d",
                        txn, a.q, a.ud, a.busy, a.done, a.err, a.laps,
                        e.q, e.ud, e.busy, e.done, e.err, e.laps);
            end else begin
               $display("txn%0d ok: q=%0d ud=%b busy=%b done=%b err=%b laps=%0d",
                        txn, a.q, a.ud, a.busy, a.done, a.err, a.laps);
            end
         end
      end
   end

   initial begin
      #1;
      chk_reset("reset_hold");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      // start on the very first edge after reset release
      tri_run(0, 0);

      // rejected starts leave q and laps alone
      step(1, 0, 0, 7, 7, 2, 0, 0, 0, 1, 1);
      step(0, 0, 0, 7, 7, 2, 0, 0, 0, 0, 1);
      step(1, 0, 0, 9, 4, 2, 0, 0, 0, 1, 1);
      step(0, 0, 0, 9, 4, 2, 0, 0, 0, 0, 1);

      // start/lo/hi/mode wiggled mid-sweep must not matter
      tri_run(1, 1);

      // repeating triangles, stop during busy cycle 20
      step(1, 0, 1, 0, 3, bq[0], bud[0], 1, 0, 0, bl[0]);
      for (int i = 1; i < 20; i++)
         step(0, 0, 1, 0, 3, bq[i], bud[i], 1, 0, 0, bl[i]);
      step(0, 1, 1, 0, 3, 1, 0, 0, 0, 0, 3);
      step(0, 0, 1, 0, 3, 1, 0, 0, 0, 0, 3);

      // stop at the peak; stop held with start in IDLE is ignored
      step(1, 1, 0, 1, 4, 1, 0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 4, 2, 0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 4, 3, 0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 4, 4, 0, 1, 0, 0, 0);
      step(0, 1, 0, 1, 4, 4, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 4, 4, 0, 0, 0, 0, 0);

      // stop at the bottom outranks the finish (no done, no lap)
      step(1, 0, 0, 1, 2, 1, 0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 2, 2, 0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 2, 1, 1, 1, 0, 0, 0);
      step(0, 1, 0, 1, 2, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0);

      // asynchronous reset at q=3, then a clean triangle
      step(1, 0, 0, 2, 5, 2, 0, 1, 0, 0, 0);
      step(0, 0, 0, 2, 5, 3, 0, 1, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_reset("reset_mid");
      #1;
      rst = 1'b0;
      tri_run(0, 0);

      repeat (2) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: got %0d pending records, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
